// File: rtl/delay_line_ctrl_pkg.sv
// delay_line_ctrl_pkg: state encoding shared by the delay line controller and its bench-facing o_State port.
package delay_line_ctrl_pkg;
  localparam int STATE_W = 2;
  localparam logic [STATE_W-1:0] S_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] S_FLUSH = 2'd1;
  localparam logic [STATE_W-1:0] S_FILL  = 2'd2;
  localparam logic [STATE_W-1:0] S_RUN   = 2'd3;
endpackage

// File: rtl/delay_tap_line.sv
// delay_tap_line: WIDTH x DEPTH shift register with clear, returning stage[i_Sel-1].
module delay_tap_line #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int DW    = $clog2(DEPTH) + 1
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Shift,
  input  logic             i_Clear,
  input  logic [WIDTH-1:0] i_Data,
  input  logic [DW-1:0]    i_Sel,
  output logic [WIDTH-1:0] o_Tap
);
  logic [WIDTH-1:0] r_Stage [DEPTH];
  logic [DW-1:0]    w_Idx;
  assign w_Idx = i_Sel - 1'b1;
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) r_Stage <= '{default: '0};
    else if (i_Clear) r_Stage <= '{default: '0};
    else if (i_Shift) begin
      r_Stage[0] <= i_Data;
      for (int k = 1; k < DEPTH; k++) r_Stage[k] <= r_Stage[k-1];
    end
  end
  // i_Sel is always 1..DEPTH, so an explicit compare mux avoids an over-wide array index
  always_comb begin
    o_Tap = '0;
    for (int k = 0; k < DEPTH; k++) if (DW'(k) == w_Idx) o_Tap = r_Stage[k];
  end
endmodule

// File: rtl/delay_line_ctrl.sv
// delay_line_ctrl: runtime-programmable delay line with config handshake.
// DELAY_LINE_CTRL_FLUSH_EN enables the FLUSH/FILL phases that suppress output until the line holds real samples.
module delay_line_ctrl
  import delay_line_ctrl_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int DW    = $clog2(DEPTH) + 1
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic               i_Cfg_Valid,
  output logic               o_Cfg_Ready,
  input  logic [DW-1:0]      i_Cfg_Delay,
  output logic               o_Cfg_Err,
  input  logic               i_Data_Valid,
  output logic               o_In_Ready,
  input  logic [WIDTH-1:0]   i_Data,
  output logic               o_Data_Valid,
  output logic [WIDTH-1:0]   o_Data,
  output logic [STATE_W-1:0] o_State
);
  logic [STATE_W-1:0] r_State;
  logic [DW-1:0]      r_Delay;
  logic               r_Cfg_Err;
  logic               r_Data_Valid;
  logic [WIDTH-1:0]   r_Data;
  logic               w_Cfg_Acc;
  logic               w_Data_Acc;
  logic               w_Emit;
  logic               w_Clamp_Err;
  logic               w_Clear;
  logic [DW-1:0]      w_Clamped;
  logic [WIDTH-1:0]   w_Tap;
  // config wins over data in the same cycle, so a sample never lands in a line about to be retargeted
  assign o_In_Ready  = (r_State == S_FILL || r_State == S_RUN) && !i_Cfg_Valid;
  assign w_Cfg_Acc   = i_Cfg_Valid && o_Cfg_Ready;
  assign w_Data_Acc  = i_Data_Valid && o_In_Ready;
  assign w_Emit      = w_Data_Acc && r_State == S_RUN;
  assign w_Clamp_Err = i_Cfg_Delay == '0 || i_Cfg_Delay > DW'(DEPTH);
  assign w_Clamped   = i_Cfg_Delay == '0 ? DW'(1) : i_Cfg_Delay > DW'(DEPTH) ? DW'(DEPTH) : i_Cfg_Delay;
`ifdef DELAY_LINE_CTRL_FLUSH_EN
  logic [DW-1:0] r_Cnt;
  assign o_Cfg_Ready = r_State != S_FLUSH;
  assign w_Clear     = r_State == S_FLUSH;
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_State <= S_IDLE;
      r_Cnt   <= '0;
    end else if (w_Cfg_Acc) r_State <= S_FLUSH;
    else if (r_State == S_FLUSH) begin
      r_State <= S_FILL;
      r_Cnt   <= '0;
    end else if (r_State == S_FILL && w_Data_Acc) begin
      r_Cnt <= r_Cnt + 1'b1;
      if (r_Cnt == r_Delay - 1'b1) r_State <= S_RUN;
    end
  end
`else
  assign o_Cfg_Ready = 1'b1;
  assign w_Clear     = 1'b0;
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) r_State <= S_IDLE;
    else if (w_Cfg_Acc) r_State <= S_RUN;
  end
`endif
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_Delay      <= DW'(1);
      r_Cfg_Err    <= 1'b0;
      r_Data_Valid <= 1'b0;
      r_Data       <= '0;
    end else begin
      r_Cfg_Err    <= w_Cfg_Acc && w_Clamp_Err;
      r_Data_Valid <= w_Emit;
      if (w_Cfg_Acc) r_Delay <= w_Clamped;
      if (w_Emit) r_Data <= w_Tap;
    end
  end
  delay_tap_line #(.DEPTH(DEPTH), .WIDTH(WIDTH), .DW(DW)) u_line (
    .i_Clk  (i_Clk),
    .i_Rst  (i_Rst),
    .i_Shift(w_Data_Acc),
    .i_Clear(w_Clear),
    .i_Data (i_Data),
    .i_Sel  (r_Delay),
    .o_Tap  (w_Tap)
  );
  assign o_State      = r_State;
  assign o_Cfg_Err    = r_Cfg_Err;
  assign o_Data_Valid = r_Data_Valid;
  assign o_Data       = r_Data;
endmodule

// File: tb/tb_delay_line_ctrl.sv
// tb_delay_line_ctrl: scenario tasks plus random traffic checked against a sample-history reference model.
module tb_delay_line_ctrl;
  localparam int DEPTH = 16;
  localparam int WIDTH = 8;
  localparam int DW    = $clog2(DEPTH) + 1;
  localparam int VW    = WIDTH + 6;
`ifdef DELAY_LINE_CTRL_FLUSH_EN
  localparam bit FE = 1'b1;
`else
  localparam bit FE = 1'b0;
`endif
  logic i_Clk = 1'b0, i_Rst = 1'b1;
  logic i_Cfg_Valid = 1'b0, i_Data_Valid = 1'b0;
  logic [DW-1:0] i_Cfg_Delay = '0;
  logic [WIDTH-1:0] i_Data = '0;
  logic o_Cfg_Ready, o_Cfg_Err, o_In_Ready, o_Data_Valid;
  logic [WIDTH-1:0] o_Data;
  logic [1:0] o_State;
  always #5 i_Clk = ~i_Clk;
  delay_line_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst),
    .i_Cfg_Valid(i_Cfg_Valid), .o_Cfg_Ready(o_Cfg_Ready), .i_Cfg_Delay(i_Cfg_Delay), .o_Cfg_Err(o_Cfg_Err),
    .i_Data_Valid(i_Data_Valid), .o_In_Ready(o_In_Ready), .i_Data(i_Data),
    .o_Data_Valid(o_Data_Valid), .o_Data(o_Data), .o_State(o_State)
  );
  int n_tests = 0, n_fail = 0;
  // model: phase 0 idle, 1 flushing, 2 streaming; hist[0] is the newest sample in the line
  int ph, m_delay, m_since;
  logic [WIDTH-1:0] hist[$];
  logic [WIDTH-1:0] e_data;
  logic e_valid, e_err, e_in, obs_in;
  function automatic logic [1:0] e_state();
    return ph == 0 ? 2'd0 : ph == 1 ? 2'd1 : (!FE || m_since >= m_delay) ? 2'd3 : 2'd2;
  endfunction
  function automatic logic [VW-1:0] exp_vec();
    return {e_state(), e_err, e_valid, e_data, !FE || ph != 1, e_in};
  endfunction
  function automatic logic [VW-1:0] obs_vec();
    return {o_State, o_Cfg_Err, o_Data_Valid, o_Data, o_Cfg_Ready, obs_in};
  endfunction
  task automatic model_reset();
    ph = 0; m_delay = 1; m_since = 0; e_data = '0; e_valid = 0; e_err = 0; e_in = 0;
    hist = {};
    repeat (DEPTH) hist.push_back('0);
  endtask
  task automatic step(input logic cv, input logic [DW-1:0] cd, input logic dv, input logic [WIDTH-1:0] d);
    logic acc_c, acc_d;
    int cl;
    i_Cfg_Valid = cv; i_Cfg_Delay = cd; i_Data_Valid = dv; i_Data = d;
    #1 obs_in = o_In_Ready;
    e_in  = ph == 2 && !cv;
    acc_c = cv && (!FE || ph != 1);
    acc_d = dv && e_in;
    cl    = cd == 0 ? 1 : (int'(cd) > DEPTH ? DEPTH : int'(cd));
    e_err = acc_c && cl != int'(cd);
    e_valid = 0;
    if (acc_d) begin
      if (!FE || m_since >= m_delay) begin
        e_valid = 1;
        e_data  = hist[m_delay-1];
      end
      hist.push_front(d);
      void'(hist.pop_back());
      m_since++;
    end
    if (acc_c) begin
      m_delay = cl;
      ph = FE ? 1 : 2;
    end else if (ph == 1) begin
      foreach (hist[i]) hist[i] = '0;
      m_since = 0;
      ph = 2;
    end
    @(posedge i_Clk);
    #1;
  endtask
  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, WIDTH'(8'h50 + i));
      n_tests++;
      if (obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL reset_idle c%0d: got %h want %h", i, obs_vec(), exp_vec()); end
    end
  endtask
  task automatic test_basic();
    step(1, 4, 0, 0);
    n_tests++;
    if (obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL basic_cfg: got %h want %h", obs_vec(), exp_vec()); end
    for (int i = 1; i <= 10; i++) begin
      step(0, 0, 1, WIDTH'(i));
      n_tests++;
      if (obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL basic s%0d: got %h want %h", i, obs_vec(), exp_vec()); end
    end
  endtask
  task automatic test_clamp();
    logic [DW-1:0] cfgs[2] = '{5'd0, 5'd20};
    for (int c = 0; c < 2; c++) begin
      step(1, cfgs[c], 0, 0);
      n_tests++;
      if (obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL clamp_cfg%0d: got %h want %h", cfgs[c], obs_vec(), exp_vec()); end
      for (int i = 0; i < 20; i++) begin
        step(0, 0, 1, WIDTH'(7 + i));
        n_tests++;
        if (obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL clamp%0d s%0d: got %h want %h", cfgs[c], i, obs_vec(), exp_vec()); end
      end
    end
  endtask
  task automatic test_gaps();
    step(1, 2, 0, 0);
    step(0, 0, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      step(0, 0, 1, WIDTH'(i));
      n_tests++;
      if (obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL gaps s%0d: got %h want %h", i, obs_vec(), exp_vec()); end
      repeat (3) begin
        step(0, 0, 0, 8'hEE);
        n_tests++;
        if (obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL gaps idle%0d: got %h want %h", i, obs_vec(), exp_vec()); end
      end
    end
  endtask
  task automatic test_reconfig();
    step(1, 4, 0, 0);
    for (int i = 1; i <= 8; i++) step(0, 0, 1, WIDTH'(i));
    step(1, 2, 0, 0);
    n_tests++;
    if (obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL reconfig_cfg: got %h want %h", obs_vec(), exp_vec()); end
    for (int i = 0; i < 5; i++) begin
      step(0, 0, i > 0, WIDTH'(19 + i));
      n_tests++;
      if (obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL reconfig c%0d: got %h want %h", i, obs_vec(), exp_vec()); end
    end
  endtask
  task automatic test_simultaneous();
    step(1, 3, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 1, WIDTH'(8'h30 + i));
    step(1, 3, 1, 8'hAA);
    n_tests++;
    if (obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL simul_cfg: got %h want %h", obs_vec(), exp_vec()); end
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 1, WIDTH'(8'h40 + i));
      n_tests++;
      if (obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL simul c%0d: got %h want %h", i, obs_vec(), exp_vec()); end
    end
  endtask
  task automatic test_async_reset();
    logic [WIDTH+4:0] got;
    step(1, 4, 0, 0);
    step(0, 0, 1, 8'h61);
    step(0, 0, 1, 8'h62);
    #2 i_Rst = 1'b1;
    #1 got = {o_State, o_Data_Valid, o_Data, o_Cfg_Err, o_Cfg_Ready};
    n_tests++;
    if (got !== {2'd0, 1'b0, {WIDTH{1'b0}}, 1'b0, 1'b1}) begin n_fail++; $display("FAIL async_reset: got %h want state0 data0 rdy1", got); end
    model_reset();
    i_Data_Valid = 1'b0;
    @(posedge i_Clk);
    #1 i_Rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, WIDTH'(8'h70 + i));
      n_tests++;
      if (obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL post_reset c%0d: got %h want %h", i, obs_vec(), exp_vec()); end
    end
    step(1, 2, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, WIDTH'(8'h80 + i));
      n_tests++;
      if (obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL recover c%0d: got %h want %h", i, obs_vec(), exp_vec()); end
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 24) == 0, DW'($urandom_range(0, 31)), $urandom_range(0, 3) != 0, WIDTH'($urandom));
      n_tests++;
      if (obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL random c%0d: got %h want %h", i, obs_vec(), exp_vec()); end
    end
  endtask
  initial begin
    model_reset();
    repeat (2) @(posedge i_Clk);
    #1 i_Rst = 1'b0;
    test_reset();
    test_basic();
    test_clamp();
    test_gaps();
    test_reconfig();
    test_simultaneous();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
